rf_dumper: RTL



---
 rtl/rf_dumper_pkg.sv | 17 +
 rtl/rf_dumper.sv | 123 ++++++++++++
 2 files changed

// File: rtl/rf_dumper_pkg.sv
// Shared CPU package: register-file geometry defaults and the dump FSM encoding.
package rf_dumper_pkg;

    // Register-file geometry defaults shared by the register file and its dumper.
    localparam int unsigned RF_NUM_REGS = 32;
    localparam int unsigned RF_ADDR_W   = 5;
    localparam int unsigned RF_DATA_W   = 32;

    // Dump sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_e;

endpackage : rf_dumper_pkg

// File: rtl/rf_dumper.sv
// Register-file dumper: walks entries 0..NUM_REGS-1 through the read port and
// streams each word out on a valid/ready handshake, ending with a done pulse.
module rf_dumper
    import rf_dumper_pkg::*;
#(
    parameter int unsigned NUM_REGS = RF_NUM_REGS,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned DATA_W   = RF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    // Index of the final entry; the counter stops here and never wraps.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_idx_q, out_idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state, counter and output-register update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (abort) begin
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_data_d  = rd_data;
                    out_idx_d   = cnt_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                // Abort wins over a handshake landing in the same cycle.
                if (abort) begin
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d       = '0;
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        // Status flags follow the state being entered so they line up with it.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Read address is the counter register itself, isolated from out_ready.
    assign rd_addr   = cnt_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule : rf_dumper
